// File: rtl/uart_tx_buffer_pkg.sv
// Shared definitions for the buffered UART transmitter: serializer state
// encoding and frame geometry constants.
package uart_tx_buffer_pkg;

   // Serializer FSM states, 2-bit encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   localparam int DATA_BITS      = 8;
   localparam int BYTES_PER_WORD = 2;
   localparam int WORD_W         = DATA_BITS * BYTES_PER_WORD;
   localparam int BAUD_W         = 16;   // covers CLKS_PER_BIT up to 65535
   localparam int BIT_IDX_W      = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_tx_buffer_fifo.sv
// Word FIFO feeding the serializer. Power-of-two depth so the pointers wrap
// naturally; occupancy is tracked with an explicit counter.
module tx_word_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_wr;
   logic             w_rd;

   // A push is taken when there is room, or when a pop frees a slot on the same edge.
   assign w_rd  = pop && (r_count != '0);
   assign w_wr  = push && (!full || w_rd);
   assign full  = (r_count == CNT_W'(DEPTH));
   assign count = r_count;
   assign dout  = r_mem[r_rd_ptr];

   // Storage array: written on accepted pushes only.
   // NOTE: the data array has no reset; only pointers and count need one to make contents invalid.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= din;
   end

   // Pointer and occupancy bookkeeping.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffered 8N1 UART transmitter. 16-bit words are queued in a small FIFO and
// sent as two frames, low byte first, with no gap between the two frames and
// one idle cycle between words.
module uart_tx_buffer
   import uart_tx_buffer_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int DEPTH        = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              transmit_enable,
   input  logic [WORD_W-1:0] data_in,
   output logic              tx,
   output logic              busy,
   output logic              full,
   output logic              overflow
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   tx_state_t            r_state;
   logic [BAUD_W-1:0]    r_baud;
   logic [BIT_IDX_W-1:0] r_bit_idx;
   logic                 r_byte_sel;
   logic [WORD_W-1:0]    r_shift;
   logic                 r_tx;
   logic                 r_overflow;

   logic [WORD_W-1:0]    w_dout;
   logic [CNT_W-1:0]     w_count;
   logic                 w_full;
   logic                 w_pop;
   logic                 w_baud_done;

   // The head word is taken the first cycle the FSM sits in IDLE with data queued.
   assign w_pop       = (r_state == ST_IDLE) && (w_count != '0);
   assign w_baud_done = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

   tx_word_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (transmit_enable),
      .pop   (w_pop),
      .din   (data_in),
      .dout  (w_dout),
      .count (w_count),
      .full  (w_full)
   );

   assign tx       = r_tx;
   assign full     = w_full;
   assign overflow = r_overflow;
   assign busy     = (r_state != ST_IDLE) || (w_count != '0);

   // Sticky drop flag: a push against a full FIFO with no simultaneous pop is lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                       r_overflow <= 1'b0;
      else if (transmit_enable && w_full && !w_pop)   r_overflow <= 1'b1;
   end

   // Serializer FSM with baud counter; the shift holder moves right one bit per
   // data bit, so after the low byte the high byte sits in the bottom eight bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_baud     <= '0;
         r_bit_idx  <= '0;
         r_byte_sel <= 1'b0;
         r_shift    <= '0;
         r_tx       <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_tx   <= 1'b1;
               r_baud <= '0;
               if (w_pop) begin
                  r_shift    <= w_dout;
                  r_state    <= ST_START;
                  r_tx       <= 1'b0;
                  r_byte_sel <= 1'b0;
                  r_bit_idx  <= '0;
               end
            end
            ST_START: begin
               if (w_baud_done) begin
                  r_baud    <= '0;
                  r_state   <= ST_DATA;
                  r_bit_idx <= '0;
                  r_tx      <= r_shift[0];
                  r_shift   <= r_shift >> 1;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            ST_DATA: begin
               if (w_baud_done) begin
                  r_baud <= '0;
                  if (r_bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
                     r_state <= ST_STOP;
                     r_tx    <= 1'b1;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                     r_tx      <= r_shift[0];
                     r_shift   <= r_shift >> 1;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            ST_STOP: begin
               if (w_baud_done) begin
                  r_baud <= '0;
                  if (!r_byte_sel) begin
                     r_byte_sel <= 1'b1;
                     r_bit_idx  <= '0;
                     r_state    <= ST_START;
                     r_tx       <= 1'b0;
                  end else begin
                     r_byte_sel <= 1'b0;
                     r_state    <= ST_IDLE;
                     r_tx       <= 1'b1;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with CLKS_PER_BIT=4, DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_buffer;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int WORD_CYCLES = 20 * CPB;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        transmit_enable = 1'b0;
   logic [15:0] data_in = '0;
   logic        tx;
   logic        busy;
   logic        full;
   logic        overflow;

   int n_pass  = 0;
   int n_total = 0;

   uart_tx_buffer #(
      .CLKS_PER_BIT (CPB),
      .DEPTH        (DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .transmit_enable (transmit_enable),
      .data_in         (data_in),
      .tx              (tx),
      .busy            (busy),
      .full            (full),
      .overflow        (overflow)
   );

   always #5 clk = ~clk;

   // Line level of serial bit n (0..19) of a word: two 8N1 frames, low byte first.
   function automatic logic exp_bit(input logic [15:0] w, input int n);
      logic [7:0] b;
      int         j;
      b = (n < 10) ? w[7:0] : w[15:8];
      j = n % 10;
      if (j == 0) return 1'b0;
      if (j == 9) return 1'b1;
      return b[j-1];
   endfunction

   // Called on the falling edge inside cycle 'first' of a word (cycle 0 = first
   // start-bit cycle). Compares tx every cycle through cycle 79, then checks the
   // idle cycle 80 is high. Returns positioned on cycle 80.
   task automatic check_word(input logic [15:0] w, input int first, input string name);
      int bad_tx   = 0;
      int bad_busy = 0;
      for (int i = first; i < WORD_CYCLES; i++) begin
         if (tx !== exp_bit(w, i / CPB)) bad_tx++;
         if (busy !== 1'b1) bad_busy++;
         @(negedge clk);
      end
      n_total++;
      if (bad_tx != 0) $display("FAIL %s tx waveform word %h: %0d wrong cycles, want 0", name, w, bad_tx);
      else n_pass++;
      n_total++;
      if (bad_busy != 0) $display("FAIL %s busy during word %h: low on %0d cycles, want 0", name, w, bad_busy);
      else n_pass++;
      n_total++;
      if (tx !== 1'b1) $display("FAIL %s idle after word %h: tx=%b want 1", name, w, tx);
      else n_pass++;
   endtask

   task automatic push_word(input logic [15:0] w);
      transmit_enable = 1'b1;
      data_in         = w;
      @(negedge clk);
      transmit_enable = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      #1;
      n_total++;
      if (tx !== 1'b1) $display("FAIL reset tx: got %b want 1", tx); else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else n_pass++;
      n_total++;
      if (full !== 1'b0) $display("FAIL reset full: got %b want 0", full); else n_pass++;
      n_total++;
      if (overflow !== 1'b0) $display("FAIL reset overflow: got %b want 0", overflow); else n_pass++;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_idle_line();
      int bad = 0;
      for (int i = 0; i < 200; i++) begin
         if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) bad++;
         @(negedge clk);
      end
      n_total++;
      if (bad != 0) $display("FAIL idle_line: %0d cycles with tx/busy/full/overflow != 1/0/0/0, want 0", bad);
      else n_pass++;
   endtask

   task automatic test_single_word();
      push_word(16'hA55A);
      n_total++;
      if (tx !== 1'b1) $display("FAIL single latency: tx=%b on push cycle, want 1", tx); else n_pass++;
      n_total++;
      if (busy !== 1'b1) $display("FAIL single busy_queued: got %b want 1", busy); else n_pass++;
      @(negedge clk);
      check_word(16'hA55A, 0, "single");
      n_total++;
      if (busy !== 1'b0) $display("FAIL single busy_end: got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_back_to_back();
      push_word(16'h0001);
      push_word(16'h8000);
      // second push edge coincided with the first pop; now in cycle 0
      check_word(16'h0001, 0, "b2b_first");
      n_total++;
      if (busy !== 1'b1) $display("FAIL b2b busy_gap: got %b want 1", busy); else n_pass++;
      @(negedge clk);
      check_word(16'h8000, 0, "b2b_second");
      n_total++;
      if (busy !== 1'b0) $display("FAIL b2b busy_end: got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_overflow();
      int extra = 0;
      for (int k = 0; k < 6; k++) begin
         transmit_enable = 1'b1;
         data_in         = 16'h1001 + 16'(k);
         @(negedge clk);
      end
      transmit_enable = 1'b0;
      // now in cycle 4 of the first word
      n_total++;
      if (full !== 1'b1) $display("FAIL ovf full: got %b want 1", full); else n_pass++;
      n_total++;
      if (overflow !== 1'b1) $display("FAIL ovf flag: got %b want 1", overflow); else n_pass++;
      check_word(16'h1001, 4, "ovf_w0");
      for (int k = 1; k < 5; k++) begin
         @(negedge clk);
         check_word(16'h1001 + 16'(k), 0, "ovf_wk");
      end
      for (int i = 0; i < 100; i++) begin
         if (tx !== 1'b1 || busy !== 1'b0) extra++;
         @(negedge clk);
      end
      n_total++;
      if (extra != 0) $display("FAIL ovf dropped_word: %0d active cycles after 5th word, want 0", extra);
      else n_pass++;
      n_total++;
      if (overflow !== 1'b1) $display("FAIL ovf sticky: got %b want 1", overflow); else n_pass++;
   endtask

   task automatic test_push_full_pop();
      logic [15:0] words [5];
      words = '{16'hC0DE, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
      apply_reset();
      n_total++;
      if (overflow !== 1'b0) $display("FAIL pfp overflow_cleared: got %b want 0", overflow); else n_pass++;
      for (int k = 0; k < 5; k++) begin
         transmit_enable = 1'b1;
         data_in         = words[k];
         @(negedge clk);
      end
      transmit_enable = 1'b0;
      // cycle 3 of C0DE, four words queued
      n_total++;
      if (full !== 1'b1) $display("FAIL pfp full: got %b want 1", full); else n_pass++;
      check_word(words[0], 3, "pfp_w0");
      // idle cycle: next edge pops 1111 and pushes 1234 into the full FIFO
      transmit_enable = 1'b1;
      data_in         = 16'h1234;
      @(negedge clk);
      transmit_enable = 1'b0;
      n_total++;
      if (overflow !== 1'b0) $display("FAIL pfp overflow: got %b want 0", overflow); else n_pass++;
      n_total++;
      if (full !== 1'b1) $display("FAIL pfp still_full: got %b want 1", full); else n_pass++;
      check_word(words[1], 0, "pfp_w1");
      for (int k = 2; k < 5; k++) begin
         @(negedge clk);
         check_word(words[k], 0, "pfp_wk");
      end
      @(negedge clk);
      check_word(16'h1234, 0, "pfp_1234");
      n_total++;
      if (busy !== 1'b0 || overflow !== 1'b0)
         $display("FAIL pfp end: busy=%b overflow=%b want 0/0", busy, overflow);
      else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      int extra = 0;
      push_word(16'h7E30);
      push_word(16'h1111);
      push_word(16'h2222);
      // cycle 1 of 7E30; advance to cycle 17 (data bit 3 of 0x30 = 0)
      repeat (16) @(negedge clk);
      n_total++;
      if (tx !== 1'b0) $display("FAIL rmf pre_reset tx: got %b want 0", tx); else n_pass++;
      #1 rst = 1'b0;
      #1;
      n_total++;
      if (tx !== 1'b1) $display("FAIL rmf tx_async: got %b want 1", tx); else n_pass++;
      n_total++;
      if (busy !== 1'b0 || full !== 1'b0)
         $display("FAIL rmf busy_full: busy=%b full=%b want 0/0", busy, full);
      else n_pass++;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      push_word(16'h00FF);
      n_total++;
      if (tx !== 1'b1) $display("FAIL rmf latency: tx=%b on push cycle, want 1", tx); else n_pass++;
      @(negedge clk);
      check_word(16'h00FF, 0, "rmf_00ff");
      for (int i = 0; i < 60; i++) begin
         if (tx !== 1'b1 || busy !== 1'b0) extra++;
         @(negedge clk);
      end
      n_total++;
      if (extra != 0) $display("FAIL rmf residual: %0d active cycles after 00FF, want 0", extra);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_idle_line();
      test_single_word();
      test_back_to_back();
      test_overflow();
      test_push_full_pop();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/uart_tx_buffer.md
UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter: DEPTH, default 4, FIFO entries of 16 bits; power of two, at least 2.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 transmit_enable  input  1  one-cycle push strobe from the CPU control FSM (TRANSMIT state).
REQ-006 data_in  input  16  register-file word captured when transmit_enable=1.
REQ-007 tx  output  1  serial line, 8N1, idle high.
REQ-008 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-009 full  output  1  FIFO holds DEPTH words.
REQ-010 overflow  output  1  sticky: a push was dropped.

Function
REQ-011 Each word is sent as two frames, low byte [7:0] first, then high byte [15:8].
REQ-012 Each frame is: start bit (0), 8 data bits LSB first, stop bit (1); each bit lasts exactly CLKS_PER_BIT cycles.
REQ-013 A word occupies exactly 20*CLKS_PER_BIT cycles on tx.
REQ-014 The high-byte start bit follows the low-byte stop bit with no gap.
REQ-015 FSM states: IDLE, START, DATA, STOP; a 1-bit byte select and a 3-bit bit index qualify DATA and STOP.
REQ-016 IDLE->START on the first edge where the FIFO is non-empty; that edge pops the head word into a 16-bit shift holder and drives tx=0.
REQ-017 START->DATA after CLKS_PER_BIT cycles.
REQ-018 DATA->STOP after the 8th bit.
REQ-019 STOP->START (high byte) when byte select=0.
REQ-020 STOP->IDLE when byte select=1.
REQ-021 IDLE lasts at least one cycle between words (tx=1).
REQ-022 Push latency: transmit_enable is sampled at edge E. With the FIFO empty and the FSM in IDLE, the word is written at E and tx falls at edge E+1.
REQ-023 Push when full: the word is dropped, FIFO contents are unchanged, and overflow is set.
REQ-024 Exception to REQ-023: if the pop of REQ-016 occurs on the same edge, the push is accepted.
REQ-025 overflow clears only on reset.
REQ-026 Push and pop on the same edge, non-full: both occur and occupancy is unchanged.
REQ-027 Read and write pointers wrap modulo DEPTH.
REQ-028 Occupancy is a counter of width log2(DEPTH)+1.
REQ-029 full = (count == DEPTH).
REQ-030 busy = (state != IDLE) || (count != 0).
REQ-031 The baud counter reloads to 0 on each bit boundary and on entry to START.
REQ-032 transmit_enable is honoured in every FSM state.

Reset
REQ-033 On rst=0, immediately and independent of clk: state=IDLE, tx=1, FIFO pointers and count=0, overflow=0, baud counter=0, bit index=0, byte select=0.
REQ-034 Reset asserted mid-frame aborts the frame and drives tx=1 at once.
REQ-035 A word in flight during reset is discarded, along with all FIFO contents.
REQ-036 After deassertion, the first transmit_enable behaves per REQ-022.
REQ-037 Outputs full=0 and busy=0 while rst=0.

Structure
REQ-038 A shared package holds the FSM state encoding (2-bit) and the frame constants: DATA_BITS=8, BYTES_PER_WORD=2.
REQ-039 The FIFO is one sub-module, tx_word_fifo, parameterised by width 16 and DEPTH; it provides push, pop, dout, count and full.
REQ-040 The serializer FSM and the baud counter live in uart_tx_buffer.

Verification (CLKS_PER_BIT=4, DEPTH=4)
REQ-041 Single word: one push of data_in=16'hA55A while idle. Required: tx falls one cycle after the push edge, then shows 0,0,1,0,1,1,0,1,0,1 then 0,1,0,1,0,0,1,0,1,1, each bit held for 4 cycles; total 80 cycles; busy falls on return to IDLE.
REQ-042 Back-to-back: pushes of 16'h0001 and 16'h8000 on consecutive cycles. Required: two 80-cycle words separated by exactly 1 idle-high cycle; bytes decode as 01,00,00,80.
REQ-043 Overflow: 6 pushes on consecutive cycles while idle. Required: the first word goes into transmission and 4 are queued; full=1; the 6th push is dropped; overflow=1; exactly 5 words are transmitted in order.
REQ-044 Push-at-full with pop: fill to full while the FSM is in STOP of the high byte, then push 16'h1234 on the pop edge. Required: the push is accepted, overflow stays 0, and the word is later transmitted.
REQ-045 Reset mid-frame: assert rst=0 during bit 3 of a low byte. Required: tx=1 the same cycle; busy=0; after release, a new push of 16'h00FF transmits cleanly with no residual words.
REQ-046 Idle line: no pushes for 200 cycles after reset. Required: tx held at 1, busy=0, full=0, overflow=0.
